// File: rtl/song_pkg.sv
// Shared definitions for the song progress bar: state encoding, default colours
// and the default tick period.
package song_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAYING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [7:0]  BORDER_COLOR_DEF = 8'hFF;
    localparam logic [7:0]  FILL_COLOR_DEF   = 8'h1C;
    localparam logic [7:0]  BG_COLOR_DEF     = 8'h00;

    // 1 ms per tick at a 100 MHz clock
    localparam logic [31:0] TICK_CYCLES_DEF  = 32'd100000;

endpackage

// File: rtl/song_progress_bar_tick_gen.sv
// Playback tick prescaler: one tick every TICK_CYCLES enabled cycles, holding
// its position while disabled so a paused partial tick resumes where it stopped.
module tick_gen
    import song_pkg::*;
#(
    parameter logic [31:0] TICK_CYCLES = TICK_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_CYCLES > 32'd1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TICK_CYCLES - 32'd1);

    logic [CW-1:0] cnt;

    // Down-counter; the terminal count is the tick cycle.
    assign tick = enable && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= LOAD;
        end else if (enable) begin
            cnt <= (cnt == '0) ? LOAD : cnt - CW'(1);
        end
    end

endmodule

// File: rtl/song_progress_bar.sv
// Song progress indicator: playback FSM, Bresenham fill datapath and a
// registered renderer for a bordered horizontal bar on the VGA overlay.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | no song; fill and counters cleared
//   PLAYING | prescaler running, ticks advance elapsed/fill
//   PAUSED  | everything held, partial tick preserved
//   DONE    | bar full; left only via reset_player/rst
module song_progress_bar
    import song_pkg::*;
#(
    parameter logic [10:0] X_COORD      = 11'd820,
    parameter logic [9:0]  Y_COORD      = 10'd72,
    parameter logic [7:0]  BAR_WIDTH    = 8'd50,
    parameter logic [7:0]  BAR_HEIGHT   = 8'd8,
    parameter int          LEN_W        = 16,
    parameter logic [31:0] TICK_CYCLES  = TICK_CYCLES_DEF,
    parameter logic [7:0]  BORDER_COLOR = BORDER_COLOR_DEF,
    parameter logic [7:0]  FILL_COLOR   = FILL_COLOR_DEF,
    parameter logic [7:0]  BG_COLOR     = BG_COLOR_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reset_player,
    input  logic             play,
    input  logic             song_done,
    input  logic [LEN_W-1:0] song_len,
    input  logic [10:0]      x,
    input  logic [9:0]       y,
    output logic [7:0]       pixel_on,
    output logic [7:0]       fill,
    output logic [1:0]       state,
    output logic             done_pulse
);

    localparam logic [LEN_W-1:0] BW_L = LEN_W'(BAR_WIDTH);

    state_t           state_q;
    logic [LEN_W-1:0] elapsed;
    logic [LEN_W-1:0] elapsed_nx;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_start;
    logic [LEN_W:0]   acc;
    logic [LEN_W:0]   acc_sum;
    logic             tick;

    assign state      = state_q;
    assign elapsed_nx = elapsed + LEN_W'(1);
    assign acc_sum    = acc + (LEN_W+1)'(BAR_WIDTH);
    // Clamping to BAR_WIDTH guarantees at most one fill step per tick.
    assign len_start  = (song_len > BW_L) ? song_len : BW_L;

    tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .enable (state_q == ST_PLAYING),
        .clear  (reset_player || (state_q == ST_IDLE)),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (rst || reset_player) begin
            state_q    <= ST_IDLE;
            fill       <= 8'd0;
            elapsed    <= '0;
            acc        <= '0;
            len_q      <= '0;
            done_pulse <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (song_done) begin
                        state_q    <= ST_DONE;
                        fill       <= BAR_WIDTH;
                        done_pulse <= 1'b1;
                    end else if (play) begin
                        state_q <= ST_PLAYING;
                        len_q   <= len_start;
                    end
                end
                ST_PLAYING, ST_PAUSED: begin
                    if (song_done) begin
                        state_q    <= ST_DONE;
                        fill       <= BAR_WIDTH;
                        done_pulse <= 1'b1;
                    end else begin
                        if (tick) begin
                            elapsed <= elapsed_nx;
                            if (acc_sum >= {1'b0, len_q}) begin
                                acc  <= acc_sum - {1'b0, len_q};
                                fill <= fill + 8'd1;
                            end else begin
                                acc <= acc_sum;
                            end
                        end
                        if (tick && (elapsed_nx == len_q)) begin
                            state_q    <= ST_DONE;
                            fill       <= BAR_WIDTH;
                            done_pulse <= 1'b1;
                        end else begin
                            state_q <= play ? ST_PLAYING : ST_PAUSED;
                        end
                    end
                end
                ST_DONE: begin
                    fill <= BAR_WIDTH;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    logic [11:0] xe, ye, x_lo, x_hi, y_lo, y_hi, col, row;
    logic [7:0]  pix_nx;

    // 12-bit compares so X_COORD+BAR_WIDTH cannot wrap at the screen edge.
    always_comb begin
        xe     = {1'b0, x};
        ye     = {2'b0, y};
        x_lo   = {1'b0, X_COORD};
        y_lo   = {2'b0, Y_COORD};
        x_hi   = x_lo + {4'b0, BAR_WIDTH};
        y_hi   = y_lo + {4'b0, BAR_HEIGHT};
        col    = xe - x_lo;
        row    = ye - y_lo;
        pix_nx = 8'h00;
        if ((xe >= x_lo) && (xe < x_hi) && (ye >= y_lo) && (ye < y_hi)) begin
            if ((col == 12'd0) || (col == {4'b0, BAR_WIDTH} - 12'd1) ||
                (row == 12'd0) || (row == {4'b0, BAR_HEIGHT} - 12'd1)) begin
                pix_nx = BORDER_COLOR;
            end else if (col < {4'b0, fill}) begin
                pix_nx = FILL_COLOR;
            end else begin
                pix_nx = BG_COLOR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_on <= 8'h00;
        end else begin
            pixel_on <= pix_nx;
        end
    end

endmodule
